// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-sequencer definitions: prefix/error bytes, decoder states, event record.
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT  = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK  = 8'hF0;
   localparam logic [7:0] PS2_ERR_ZERO = 8'h00;
   localparam logic [7:0] PS2_ERR_ONES = 8'hFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_e;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } ps2_event_t;

   localparam int PS2_EVENT_W = $bits(ps2_event_t);

   function automatic logic ps2_is_err_byte(input logic [7:0] b);
      return (b == PS2_ERR_ZERO) || (b == PS2_ERR_ONES);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Power-of-two event FIFO; a simultaneous push and pop both succeed even when full.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  ps2_event_t din,
   input  logic       pop,
   output ps2_event_t dout,
   output logic       full,
   output logic       empty
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

   ps2_event_t      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic            do_pop;
   logic            do_push;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Head is forced to zero while empty so stale storage never leaks out.
   assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into {code,ext,brk} events and queues them.
// Optional make-repeat suppression is built when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_scan_sequencer
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] key,
   input  logic       ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       ev_valid,
   input  logic       ev_ack,
   output logic       overflow,
   input  logic       ovf_clr,
   output logic       proto_err
);

   localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   ps2_state_e     state_q;
   ps2_state_e     state_d;
   logic           ready_q;
   logic [TW-1:0]  timer_q;
   logic           proto_err_q;
   logic           err_d;
   logic           overflow_q;
   logic           accept;
   logic           timeout;
   logic           dec_push;
   ps2_event_t     dec_ev;
   logic           push;
   logic           fifo_full;
   logic           fifo_empty;
   logic           pop;
   logic           drop;
   ps2_event_t     head;

   assign accept  = ready && !ready_q;
   assign timeout = !accept && (state_q != IDLE) && (timer_q == TIMER_LAST);

   always_comb begin
      state_d     = state_q;
      err_d       = 1'b0;
      dec_push    = 1'b0;
      dec_ev.code = key;
      dec_ev.ext  = 1'b0;
      dec_ev.brk  = 1'b0;
      if (accept) begin
         if (ps2_is_err_byte(key)) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (key == PS2_PFX_EXT) begin
                     state_d = EXT;
                  end else if (key == PS2_PFX_BRK) begin
                     state_d = BRK;
                  end else begin
                     dec_push = 1'b1;
                  end
               end
               EXT: begin
                  if (key == PS2_PFX_BRK) begin
                     state_d = EXT_BRK;
                  end else if (key == PS2_PFX_EXT) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end else begin
                     state_d    = IDLE;
                     dec_push   = 1'b1;
                     dec_ev.ext = 1'b1;
                  end
               end
               BRK, EXT_BRK: begin
                  state_d = IDLE;
                  if ((key == PS2_PFX_EXT) || (key == PS2_PFX_BRK)) begin
                     err_d = 1'b1;
                  end else begin
                     dec_push   = 1'b1;
                     dec_ev.ext = (state_q == EXT_BRK);
                     dec_ev.brk = 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end else if (timeout) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   // Decoder state, edge detector, prefix timer and error pulse advance together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         timer_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready;
         proto_err_q <= err_d;
         if (accept || (state_q == IDLE) || timeout) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + 1'b1;
         end
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       hold_vld_q;
   logic [7:0] hold_code_q;
   logic       hold_ext_q;
   logic       hold_match;

   assign hold_match = hold_vld_q && (hold_code_q == dec_ev.code) && (hold_ext_q == dec_ev.ext);
   assign push       = dec_push && !(hold_match && !dec_ev.brk);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_vld_q <= 1'b0;
      end else if (dec_push) begin
         if (!dec_ev.brk) begin
            hold_vld_q <= 1'b1;
         end else if (hold_match) begin
            hold_vld_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (dec_push && !dec_ev.brk) begin
         hold_code_q <= dec_ev.code;
         hold_ext_q  <= dec_ev.ext;
      end
   end
`else
   assign push = dec_push;
`endif

   assign pop  = ev_ack && !fifo_empty;
   assign drop = push && fifo_full && !pop;

   // A drop on the same edge as ovf_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (ovf_clr) begin
         overflow_q <= 1'b0;
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (dec_ev),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ev_valid  = !fifo_empty;
   assign ev_code   = head.code;
   assign ev_ext    = head.ext;
   assign ev_break  = head.brk;
   assign overflow  = overflow_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: vector table plus hand sequences, scoreboarded event queue.
module tb_ps2_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] key = 8'h00;
   logic       ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       ev_valid;
   logic       ev_ack = 1'b0;
   logic       overflow;
   logic       ovf_clr = 1'b0;
   logic       proto_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] k;
      bit         push;
      logic [9:0] ev;
      bit         perr;
   } vec_t;

   logic [9:0] sb[$];
   vec_t       vecs[18];
   vec_t       tvecs[6];

   always #5 clk = ~clk;

   ps2_scan_sequencer #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .ready     (ready),
      .ev_code   (ev_code),
      .ev_ext    (ev_ext),
      .ev_break  (ev_break),
      .ev_valid  (ev_valid),
      .ev_ack    (ev_ack),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .proto_err (proto_err)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1;
      check("rst_valid", ev_valid, 0);
      check("rst_event", {ev_code, ev_ext, ev_break}, 0);
      check("rst_ovf", overflow, 0);
      check("rst_perr", proto_err, 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] k, input bit clr, output bit perr);
      @(negedge clk);
      key     = k;
      ready   = 1'b1;
      ovf_clr = clr;
      @(negedge clk);
      ready   = 1'b0;
      ovf_clr = 1'b0;
      perr    = proto_err;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      @(negedge clk);
      while (ev_valid && n < 16) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_extra: got event %h expected none", nm, {ev_code, ev_ext, ev_break});
         end else begin
            check(nm, {ev_code, ev_ext, ev_break}, sb.pop_front());
         end
         ev_ack = 1'b1;
         @(negedge clk);
         n++;
      end
      ev_ack = 1'b0;
      check({nm, "_left"}, sb.size(), 0);
      check({nm, "_zero"}, {ev_code, ev_ext, ev_break}, 0);
   endtask

   task automatic apply_vec(input vec_t v, input string nm);
      bit perr;
      if (v.push) sb.push_back(v.ev);
      send_byte(v.k, 1'b0, perr);
      check({nm, "_perr"}, perr, v.perr);
      check({nm, "_valid"}, ev_valid, v.push);
      drain(nm);
   endtask

   initial begin
      bit perr;
      int n;

      vecs[0]  = '{8'h1C, 1, {8'h1C, 1'b0, 1'b0}, 0};
      vecs[1]  = '{8'hE0, 0, 10'h0, 0};
      vecs[2]  = '{8'hF0, 0, 10'h0, 0};
      vecs[3]  = '{8'h75, 1, {8'h75, 1'b1, 1'b1}, 0};
      vecs[4]  = '{8'hF0, 0, 10'h0, 0};
      vecs[5]  = '{8'h1C, 1, {8'h1C, 1'b0, 1'b1}, 0};
      vecs[6]  = '{8'hE0, 0, 10'h0, 0};
      vecs[7]  = '{8'h6B, 1, {8'h6B, 1'b1, 1'b0}, 0};
      vecs[8]  = '{8'hE0, 0, 10'h0, 0};
      vecs[9]  = '{8'hE0, 0, 10'h0, 1};
      vecs[10] = '{8'hF0, 0, 10'h0, 0};
      vecs[11] = '{8'hF0, 0, 10'h0, 1};
      vecs[12] = '{8'h00, 0, 10'h0, 1};
      vecs[13] = '{8'hE0, 0, 10'h0, 0};
      vecs[14] = '{8'hFF, 0, 10'h0, 1};
      vecs[15] = '{8'h29, 1, {8'h29, 1'b0, 1'b0}, 0};
      vecs[16] = '{8'hF0, 0, 10'h0, 0};
      vecs[17] = '{8'hE0, 0, 10'h0, 1};

`ifdef PS2_TYPEMATIC_FILTER_EN
      tvecs[0] = '{8'h1C, 1, {8'h1C, 1'b0, 1'b0}, 0};
      tvecs[1] = '{8'h1C, 0, 10'h0, 0};
      tvecs[2] = '{8'h1C, 0, 10'h0, 0};
`else
      tvecs[0] = '{8'h1C, 1, {8'h1C, 1'b0, 1'b0}, 0};
      tvecs[1] = '{8'h1C, 1, {8'h1C, 1'b0, 1'b0}, 0};
      tvecs[2] = '{8'h1C, 1, {8'h1C, 1'b0, 1'b0}, 0};
`endif
      tvecs[3] = '{8'hF0, 0, 10'h0, 0};
      tvecs[4] = '{8'h1C, 1, {8'h1C, 1'b0, 1'b1}, 0};
      tvecs[5] = '{8'h1C, 1, {8'h1C, 1'b0, 1'b0}, 0};

      do_reset();
      for (int i = 0; i < 18; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Queued events and a pending prefix are lost across reset.
      send_byte(8'h15, 1'b0, perr);
      send_byte(8'hE0, 1'b0, perr);
      do_reset();
      sb.push_back({8'h1C, 1'b0, 1'b0});
      send_byte(8'h1C, 1'b0, perr);
      drain("post_rst");

      // Level-held ready produces a single accept.
      sb.push_back({8'h3A, 1'b0, 1'b0});
      @(negedge clk);
      key = 8'h3A;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      ready = 1'b0;
      drain("held_ready");

      // Overflow with no consumer, sticky flag and clear priority.
      do_reset();
      sb.push_back({8'h15, 2'b00});
      sb.push_back({8'h16, 2'b00});
      sb.push_back({8'h1E, 2'b00});
      sb.push_back({8'h26, 2'b00});
      send_byte(8'h15, 1'b0, perr);
      send_byte(8'h16, 1'b0, perr);
      send_byte(8'h1E, 1'b0, perr);
      send_byte(8'h26, 1'b0, perr);
      check("ovf_before", overflow, 0);
      send_byte(8'h25, 1'b0, perr);
      check("ovf_set", overflow, 1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf_clr", overflow, 0);
      send_byte(8'h2E, 1'b1, perr);
      check("ovf_drop_wins", overflow, 1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      drain("ovf_fifo");

      // Timeout on a dangling break prefix, then clean decode.
      do_reset();
      send_byte(8'hF0, 1'b0, perr);
      check("to_no_early", perr, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!proto_err && n < 40);
      check("timeout_cycles", n, 20);
      @(negedge clk);
      check("timeout_pulse", proto_err, 0);
      sb.push_back({8'h1C, 1'b0, 1'b0});
      send_byte(8'h1C, 1'b0, perr);
      drain("after_to");

      // Full FIFO with simultaneous pop and push.
      do_reset();
      sb.push_back({8'h15, 2'b00});
      sb.push_back({8'h16, 2'b00});
      sb.push_back({8'h1E, 2'b00});
      sb.push_back({8'h26, 2'b00});
      send_byte(8'h15, 1'b0, perr);
      send_byte(8'h16, 1'b0, perr);
      send_byte(8'h1E, 1'b0, perr);
      send_byte(8'h26, 1'b0, perr);
      check("full_head", {ev_code, ev_ext, ev_break}, sb.pop_front());
      sb.push_back({8'h2E, 2'b00});
      @(negedge clk);
      key = 8'h2E;
      ready = 1'b1;
      ev_ack = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      ev_ack = 1'b0;
      check("full_pp_ovf", overflow, 0);
      drain("full_pp");

      // Auto-repeat handling.
      do_reset();
      for (int i = 0; i < 6; i++) apply_vec(tvecs[i], $sformatf("typ%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ps2_scan_sequencer.md
PS2_SCAN_SEQUENCER -- requirements
Module: ps2_scan_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max clocks a prefix may wait for its next byte.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port key, input, 8, scan byte from the keyboard decoder.
REQ-006 SHALL have port ready, input, 1, decoder byte-valid level; a new byte is each 0->1 transition.
REQ-007 SHALL have port ev_code, output, 8, head event scan code.
REQ-008 SHALL have port ev_ext, output, 1, head event carried an E0 prefix.
REQ-009 SHALL have port ev_break, output, 1, head event is a release (F0 prefix).
REQ-010 SHALL have port ev_valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port ev_ack, input, 1, consumer pops head when ev_valid=1.
REQ-012 SHALL have port overflow, output, 1, sticky: an event was dropped.
REQ-013 SHALL have port ovf_clr, input, 1, clears overflow.
REQ-014 SHALL have port proto_err, output, 1, one-cycle pulse on protocol error.

Function
REQ-015 Byte accepted on a clock edge where ready=1 and registered ready_q=0; ready held high yields exactly one accept.
REQ-016 FSM states IDLE, EXT, BRK, EXT_BRK.
REQ-017 IDLE: E0->EXT; F0->BRK; other byte->push {code,ext=0,brk=0}, stay IDLE.
REQ-018 EXT: F0->EXT_BRK; other byte (not E0)->push {code,1,0}, IDLE.
REQ-019 BRK: data byte->push {code,0,1}, IDLE. EXT_BRK: data byte->push {code,1,1}, IDLE.
REQ-020 E0 in EXT/BRK/EXT_BRK, or F0 in BRK/EXT_BRK: proto_err pulse, IDLE, no push.
REQ-021 Byte 00 or FF in any state: discarded, proto_err pulse, IDLE.
REQ-022 Timeout counter clears on each accept and in IDLE; increments in any other state; on reaching TIMEOUT_CYCLES: IDLE, proto_err pulse.
REQ-023 Latency: push written on the accepting edge; ev_valid=1 and ev_* valid after that edge (1 clock).
REQ-024 Pop on edge where ev_valid=1 and ev_ack=1; ev_ack with ev_valid=0 ignored.
REQ-025 Push and pop on the same edge both take effect, including when full; occupancy unchanged.
REQ-026 Push when full without pop: event dropped, overflow set next cycle.
REQ-027 ovf_clr clears overflow; a drop on the same edge wins (overflow stays 1).
REQ-028 Pointers wrap modulo FIFO_DEPTH; separate count of log2(FIFO_DEPTH)+1 bits distinguishes full/empty.
REQ-029 ev_code/ev_ext/ev_break SHALL be 0 when ev_valid=0.

Reset
REQ-030 rst_n=0 asynchronously forces: FSM IDLE, ready_q=0, timer 0, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, overflow=0, proto_err=0.
REQ-031 Reset mid-sequence discards pending prefix and all queued events; first byte after release is decoded from IDLE.

Configuration
REQ-032 Macro PS2_TYPEMATIC_FILTER_EN defined: block holds last make {code,ext}; a make equal to it is not pushed; a break matching it clears the holder; holder reset to invalid.
REQ-033 Macro undefined: every make is pushed, including auto-repeats; no holder logic present.

Structure
REQ-034 Package ps2_pkg SHALL hold PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, error codes 8'h00/8'hFF, FSM state enum, event struct {code,ext,brk}.
REQ-035 FIFO SHALL be sub-module ps2_event_fifo (parameter DEPTH, 10-bit entries, push/pop/full/empty); FSM, timer, filter in top.

Verification
REQ-036 Bytes 1C -> one event {1C,0,0}; ev_valid 1 clock after accept.
REQ-037 Bytes E0,F0,75 -> one event {75,1,1}; no event for prefixes.
REQ-038 FIFO_DEPTH=4, no ack, push 5 makes 15,16,1E,26,25 -> first four held in order, overflow=1; ovf_clr -> overflow=0.
REQ-039 TIMEOUT_CYCLES=20: F0 then idle 20 clocks -> proto_err pulse; next byte 1C -> {1C,0,0}.
REQ-040 Full FIFO with ev_ack=1 while byte 2E accepted -> head popped, 2E enqueued, overflow stays 0.
REQ-041 With PS2_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C -> events {1C,0,0},{1C,0,1},{1C,0,0}; without: five events.
